// File: rtl/rf_pkg.sv
// Shared definitions for the register file arbiter.
// Register file geometry, arbitration mode encodings and lock FSM states.
package rf_pkg;

  localparam int RF_AW = 4;
  localparam int RF_DW = 16;

  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

  typedef enum logic [1:0] {
    LK_UNLOCKED = 2'd0,
    LK_LOCKED0  = 2'd1,
    LK_LOCKED1  = 2'd2
  } lock_state_t;

endpackage

// File: rtl/rf_rsp_slot.sv
// One response holding slot for a requester port.
// Ports:
//   clk, reset        clock and asynchronous active-low reset
//   load              capture op1_in/op2_in and mark the slot valid
//   consume           the consumer takes the current contents
//   op1_in, op2_in    register file read data to capture
//   valid, op1, op2   held response
//   free              the slot can accept a new load this cycle
module rf_rsp_slot
  import rf_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             consume,
  input  logic [RF_DW-1:0] op1_in,
  input  logic [RF_DW-1:0] op2_in,
  output logic             valid,
  output logic [RF_DW-1:0] op1,
  output logic [RF_DW-1:0] op2,
  output logic             free
);

  // A slot being drained this cycle can be refilled in the same cycle.
  assign free = !valid || consume;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      op1   <= '0;
      op2   <= '0;
    end else if (load) begin
      valid <= 1'b1;
      op1   <= op1_in;
      op2   <= op2_in;
    end else if (consume) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Two-port arbiter in front of a single 16x16 register file.
// Port 0 is the datapath control unit, port 1 the debug/load port.
// One access is granted per cycle (round-robin or fixed priority); each
// access returns both read operands through a registered response slot.
// A port may hold the grant across beats with reqN_lock.
// Ports:
//   clk, reset                       clock, asynchronous active-low reset
//   reqN_valid/ready/write/lock      request handshake and controls
//   reqN_addr1/addr2/wdata           operand addresses and write data
//   rspN_valid/ready/op1/op2         response channel
//   rf_readReg1/readReg2/wrData/RegWrite  register file drive
//   rf_op1/rf_op2                    register file combinational read data
//
// state       | meaning
// LK_UNLOCKED | normal arbitration between eligible ports
// LK_LOCKED0  | only port 0 may be granted
// LK_LOCKED1  | only port 1 may be granted
module regfile_arbiter
  import rf_pkg::*;
#(
  parameter int PRIO_MODE = PRIO_RR
)
(
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic             req0_write,
  input  logic             req0_lock,
  input  logic [RF_AW-1:0] req0_addr1,
  input  logic [RF_AW-1:0] req0_addr2,
  input  logic [RF_DW-1:0] req0_wdata,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [RF_DW-1:0] rsp0_op1,
  output logic [RF_DW-1:0] rsp0_op2,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic             req1_write,
  input  logic             req1_lock,
  input  logic [RF_AW-1:0] req1_addr1,
  input  logic [RF_AW-1:0] req1_addr2,
  input  logic [RF_DW-1:0] req1_wdata,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [RF_DW-1:0] rsp1_op1,
  output logic [RF_DW-1:0] rsp1_op2,
  output logic [RF_AW-1:0] rf_readReg1,
  output logic [RF_AW-1:0] rf_readReg2,
  output logic [RF_DW-1:0] rf_wrData,
  output logic             rf_RegWrite,
  input  logic [RF_DW-1:0] rf_op1,
  input  logic [RF_DW-1:0] rf_op2
);

  lock_state_t lock_state;
  logic        last_grant;   // index of the port granted most recently
  logic        free0, free1;
  logic        elig0, elig1;
  logic        grant0, grant1;

  // Reset gates eligibility so nothing reaches the register file while
  // reset is held, even with requests pending.
  assign elig0 = reset && req0_valid && free0;
  assign elig1 = reset && req1_valid && free1;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    case (lock_state)
      LK_LOCKED0: grant0 = elig0;
      LK_LOCKED1: grant1 = elig1;
      default: begin
        if (PRIO_MODE == PRIO_FIXED) begin
          grant0 = elig0;
          grant1 = elig1 && !elig0;
        end else if (elig0 && elig1) begin
          grant0 = last_grant;
          grant1 = !last_grant;
        end else begin
          grant0 = elig0;
          grant1 = elig1;
        end
      end
    endcase
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    rf_readReg1 = '0;
    rf_readReg2 = '0;
    rf_wrData   = '0;
    rf_RegWrite = 1'b0;
    if (grant0) begin
      rf_readReg1 = req0_addr1;
      rf_readReg2 = req0_addr2;
      rf_wrData   = req0_wdata;
      rf_RegWrite = req0_write;
    end else if (grant1) begin
      rf_readReg1 = req1_addr1;
      rf_readReg2 = req1_addr2;
      rf_wrData   = req1_wdata;
      rf_RegWrite = req1_write;
    end
  end

  // Lock FSM and last-grant pointer; a lock is only entered or left by an
  // accepted beat of its owner, never by dropping valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_state <= LK_UNLOCKED;
      last_grant <= 1'b1;
    end else if (grant0) begin
      last_grant <= 1'b0;
      lock_state <= req0_lock ? LK_LOCKED0 : LK_UNLOCKED;
    end else if (grant1) begin
      last_grant <= 1'b1;
      lock_state <= req1_lock ? LK_LOCKED1 : LK_UNLOCKED;
    end
  end

  rf_rsp_slot u_slot0 (
    .clk     (clk),
    .reset   (reset),
    .load    (grant0),
    .consume (rsp0_ready),
    .op1_in  (rf_op1),
    .op2_in  (rf_op2),
    .valid   (rsp0_valid),
    .op1     (rsp0_op1),
    .op2     (rsp0_op2),
    .free    (free0)
  );

  rf_rsp_slot u_slot1 (
    .clk     (clk),
    .reset   (reset),
    .load    (grant1),
    .consume (rsp1_ready),
    .op1_in  (rf_op1),
    .op2_in  (rf_op2),
    .valid   (rsp1_valid),
    .op1     (rsp1_op1),
    .op2     (rsp1_op2),
    .free    (free1)
  );

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter: a round-robin instance with a
// register file model, plus a fixed-priority instance sharing the requests.
module tb_regfile_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        req0_valid, req0_ready, req0_write, req0_lock;
  logic [3:0]  req0_addr1, req0_addr2;
  logic [15:0] req0_wdata;
  logic        rsp0_valid, rsp0_ready;
  logic [15:0] rsp0_op1, rsp0_op2;
  logic        req1_valid, req1_ready, req1_write, req1_lock;
  logic [3:0]  req1_addr1, req1_addr2;
  logic [15:0] req1_wdata;
  logic        rsp1_valid, rsp1_ready;
  logic [15:0] rsp1_op1, rsp1_op2;
  logic [3:0]  rf_readReg1, rf_readReg2;
  logic [15:0] rf_wrData, rf_op1, rf_op2;
  logic        rf_RegWrite;

  logic        fx_req0_ready, fx_req1_ready, fx_rsp0_valid, fx_rsp1_valid;
  logic [15:0] fx_rsp0_op1, fx_rsp0_op2, fx_rsp1_op1, fx_rsp1_op2;
  logic [3:0]  fx_rf_readReg1, fx_rf_readReg2;
  logic [15:0] fx_rf_wrData, fx_rf_op1, fx_rf_op2;
  logic        fx_rf_RegWrite;

  logic [15:0] regs [16];
  logic        load_regs = 1'b1;

  // Register file model: combinational read, write on the clock edge.
  assign rf_op1    = regs[rf_readReg1];
  assign rf_op2    = regs[rf_readReg2];
  assign fx_rf_op1 = regs[fx_rf_readReg1];
  assign fx_rf_op2 = regs[fx_rf_readReg2];

  always @(posedge clk) begin
    if (load_regs) begin
      for (int i = 0; i < 16; i++) regs[i] <= 16'h0000;
      regs[1] <= 16'h1F00;
      regs[2] <= 16'h0054;
      regs[3] <= 16'hF70F;
      regs[8] <= 16'hAAAA;
    end else if (rf_RegWrite) begin
      regs[rf_readReg1] <= rf_wrData;
    end
  end

  regfile_arbiter #(.PRIO_MODE(0)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
    .req0_lock(req0_lock), .req0_addr1(req0_addr1), .req0_addr2(req0_addr2),
    .req0_wdata(req0_wdata), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_op1(rsp0_op1), .rsp0_op2(rsp0_op2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
    .req1_lock(req1_lock), .req1_addr1(req1_addr1), .req1_addr2(req1_addr2),
    .req1_wdata(req1_wdata), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_op1(rsp1_op1), .rsp1_op2(rsp1_op2),
    .rf_readReg1(rf_readReg1), .rf_readReg2(rf_readReg2), .rf_wrData(rf_wrData),
    .rf_RegWrite(rf_RegWrite), .rf_op1(rf_op1), .rf_op2(rf_op2)
  );

  regfile_arbiter #(.PRIO_MODE(1)) dut_fx (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(fx_req0_ready), .req0_write(req0_write),
    .req0_lock(req0_lock), .req0_addr1(req0_addr1), .req0_addr2(req0_addr2),
    .req0_wdata(req0_wdata), .rsp0_valid(fx_rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_op1(fx_rsp0_op1), .rsp0_op2(fx_rsp0_op2),
    .req1_valid(req1_valid), .req1_ready(fx_req1_ready), .req1_write(req1_write),
    .req1_lock(req1_lock), .req1_addr1(req1_addr1), .req1_addr2(req1_addr2),
    .req1_wdata(req1_wdata), .rsp1_valid(fx_rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_op1(fx_rsp1_op1), .rsp1_op2(fx_rsp1_op2),
    .rf_readReg1(fx_rf_readReg1), .rf_readReg2(fx_rf_readReg2),
    .rf_wrData(fx_rf_wrData), .rf_RegWrite(fx_rf_RegWrite),
    .rf_op1(fx_rf_op1), .rf_op2(fx_rf_op2)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic idle_all();
    req0_valid = 0; req0_write = 0; req0_lock = 0;
    req0_addr1 = 0; req0_addr2 = 0; req0_wdata = 0;
    req1_valid = 0; req1_write = 0; req1_lock = 0;
    req1_addr1 = 0; req1_addr2 = 0; req1_wdata = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle_all();
    rsp0_ready = 1; rsp1_ready = 1;
    reset = 0;
    @(negedge clk);
    reset = 1;
  endtask

  task automatic test_reset();
    idle_all();
    rsp0_ready = 1; rsp1_ready = 1;
    reset = 0;
    repeat (2) @(negedge clk);
    load_regs = 0;
    n_checks++; if (rsp0_valid !== 1'b0) $display("FAIL reset_rsp0_valid: got %b expected 0", rsp0_valid); else n_pass++;
    n_checks++; if (rsp1_valid !== 1'b0) $display("FAIL reset_rsp1_valid: got %b expected 0", rsp1_valid); else n_pass++;
    n_checks++; if ({rsp0_op1, rsp0_op2, rsp1_op1, rsp1_op2} !== 64'h0) $display("FAIL reset_ops: got %h expected 0", {rsp0_op1, rsp0_op2, rsp1_op1, rsp1_op2}); else n_pass++;
    reset = 1;
    #1;
    n_checks++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL idle_ready: got %b expected 00", {req0_ready, req1_ready}); else n_pass++;
    n_checks++; if ({rf_readReg1, rf_readReg2, rf_wrData, rf_RegWrite} !== 25'h0) $display("FAIL idle_rf: got %h expected 0", {rf_readReg1, rf_readReg2, rf_wrData, rf_RegWrite}); else n_pass++;
  endtask

  task automatic test_single_read();
    @(negedge clk);
    req0_valid = 1; req0_addr1 = 1; req0_addr2 = 2;
    #1;
    n_checks++; if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL read_ready: got %b expected 10", {req0_ready, req1_ready}); else n_pass++;
    n_checks++; if ({rf_readReg1, rf_readReg2, rf_RegWrite} !== 9'b0001_0010_0) $display("FAIL read_rf_addr: got %h expected 024", {rf_readReg1, rf_readReg2, rf_RegWrite}); else n_pass++;
    @(negedge clk);
    n_checks++; if (rsp0_valid !== 1'b1) $display("FAIL read_rsp_valid: got %b expected 1", rsp0_valid); else n_pass++;
    n_checks++; if ({rsp0_op1, rsp0_op2} !== 32'h1F00_0054) $display("FAIL read_ops: got %h expected 1f000054", {rsp0_op1, rsp0_op2}); else n_pass++;
    idle_all();
    @(negedge clk);
    n_checks++; if (rsp0_valid !== 1'b0) $display("FAIL read_release: got %b expected 0", rsp0_valid); else n_pass++;
  endtask

  task automatic test_tie();
    logic exp0;
    apply_reset();
    @(negedge clk);
    req0_valid = 1; req0_addr1 = 1; req0_addr2 = 2;
    req1_valid = 1; req1_addr1 = 2; req1_addr2 = 1;
    for (int i = 0; i < 4; i++) begin
      exp0 = (i % 2 == 0);
      #1;
      n_checks++; if ({req0_ready, req1_ready} !== {exp0, !exp0}) $display("FAIL tie_rr_%0d: got %b expected %b", i, {req0_ready, req1_ready}, {exp0, !exp0}); else n_pass++;
      n_checks++; if ({fx_req0_ready, fx_req1_ready} !== 2'b10) $display("FAIL tie_fixed_%0d: got %b expected 10", i, {fx_req0_ready, fx_req1_ready}); else n_pass++;
      @(negedge clk);
    end
    n_checks++; if ({rsp1_valid, rsp1_op1, rsp1_op2} !== {1'b1, 32'h0054_1F00}) $display("FAIL tie_rsp1: got %h expected 1_00541f00", {rsp1_valid, rsp1_op1, rsp1_op2}); else n_pass++;
    idle_all();
  endtask

  task automatic test_swap();
    @(negedge clk);
    req1_valid = 1; req1_write = 1; req1_addr1 = 3; req1_addr2 = 0; req1_wdata = 16'h1234;
    #1;
    n_checks++; if ({req1_ready, rf_RegWrite, rf_readReg1, rf_wrData} !== {2'b11, 4'd3, 16'h1234}) $display("FAIL swap_rf: got %h expected 331234", {req1_ready, rf_RegWrite, rf_readReg1, rf_wrData}); else n_pass++;
    @(negedge clk);
    n_checks++; if ({rsp1_valid, rsp1_op1} !== {1'b1, 16'hF70F}) $display("FAIL swap_old: got %h expected 1f70f", {rsp1_valid, rsp1_op1}); else n_pass++;
    req1_write = 0;
    @(negedge clk);
    n_checks++; if (rsp1_op1 !== 16'h1234) $display("FAIL swap_new: got %h expected 1234", rsp1_op1); else n_pass++;
    idle_all();
  endtask

  task automatic test_lock();
    apply_reset();
    @(negedge clk);
    req0_valid = 1; req0_lock = 1; req0_addr1 = 8; req0_addr2 = 1;
    req1_valid = 1; req1_addr1 = 1; req1_addr2 = 2;
    #1;
    n_checks++; if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL lock_first: got %b expected 10", {req0_ready, req1_ready}); else n_pass++;
    @(negedge clk);
    n_checks++; if (rsp0_op1 !== 16'hAAAA) $display("FAIL lock_beat1_op1: got %h expected aaaa", rsp0_op1); else n_pass++;
    req0_valid = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (req1_ready !== 1'b0) $display("FAIL lock_hold_%0d: got %b expected 0", i, req1_ready); else n_pass++;
      @(negedge clk);
    end
    req0_valid = 1; req0_lock = 0; req0_write = 1; req0_wdata = 16'h5555;
    #1;
    n_checks++; if ({req0_ready, req1_ready, rf_RegWrite} !== 3'b101) $display("FAIL lock_unlock_beat: got %b expected 101", {req0_ready, req1_ready, rf_RegWrite}); else n_pass++;
    @(negedge clk);
    req0_valid = 0; req0_write = 0;
    #1;
    n_checks++; if ({rsp0_valid, rsp0_op1} !== {1'b1, 16'hAAAA}) $display("FAIL lock_beat2_op1: got %h expected 1aaaa", {rsp0_valid, rsp0_op1}); else n_pass++;
    n_checks++; if (req1_ready !== 1'b1) $display("FAIL lock_after_release: got %b expected 1", req1_ready); else n_pass++;
    @(negedge clk);
    idle_all();
    n_checks++; if (regs[8] !== 16'h5555) $display("FAIL lock_write_r8: got %h expected 5555", regs[8]); else n_pass++;
  endtask

  task automatic test_backpressure();
    apply_reset();
    @(negedge clk);
    rsp0_ready = 0;
    req0_valid = 1; req0_addr1 = 1; req0_addr2 = 2;
    @(negedge clk);
    req0_addr1 = 2; req0_addr2 = 1;
    req1_valid = 1; req1_addr1 = 3; req1_addr2 = 8;
    #1;
    n_checks++; if ({req0_ready, req1_ready} !== 2'b01) $display("FAIL bp_stall: got %b expected 01", {req0_ready, req1_ready}); else n_pass++;
    @(negedge clk);
    n_checks++; if ({rsp1_valid, rsp1_op1, rsp1_op2} !== {1'b1, 32'h1234_5555}) $display("FAIL bp_port1_served: got %h expected 1_12345555", {rsp1_valid, rsp1_op1, rsp1_op2}); else n_pass++;
    n_checks++; if ({rsp0_valid, rsp0_op1} !== {1'b1, 16'h1F00}) $display("FAIL bp_hold: got %h expected 11f00", {rsp0_valid, rsp0_op1}); else n_pass++;
    req1_valid = 0;
    rsp0_ready = 1;
    #1;
    n_checks++; if (req0_ready !== 1'b1) $display("FAIL bp_release_ready: got %b expected 1", req0_ready); else n_pass++;
    @(negedge clk);
    n_checks++; if ({rsp0_valid, rsp0_op1, rsp0_op2} !== {1'b1, 32'h0054_1F00}) $display("FAIL bp_reload: got %h expected 1_00541f00", {rsp0_valid, rsp0_op1, rsp0_op2}); else n_pass++;
    idle_all();
  endtask

  task automatic test_reset_in_lock();
    apply_reset();
    @(negedge clk);
    rsp1_ready = 0;
    req1_valid = 1; req1_lock = 1; req1_addr1 = 1; req1_addr2 = 2;
    @(negedge clk);
    n_checks++; if ({rsp1_valid, rsp1_op1} !== {1'b1, 16'h1F00}) $display("FAIL rl_rsp1: got %h expected 11f00", {rsp1_valid, rsp1_op1}); else n_pass++;
    req1_valid = 0;
    req0_valid = 1; req0_write = 1; req0_addr1 = 5; req0_wdata = 16'hDEAD;
    #1;
    n_checks++; if (req0_ready !== 1'b0) $display("FAIL rl_locked_out: got %b expected 0", req0_ready); else n_pass++;
    reset = 0;
    #1;
    n_checks++; if ({rsp0_valid, rsp1_valid, req0_ready, req1_ready, rf_RegWrite} !== 5'b0) $display("FAIL rl_async_clear: got %b expected 00000", {rsp0_valid, rsp1_valid, req0_ready, req1_ready, rf_RegWrite}); else n_pass++;
    @(negedge clk);
    n_checks++; if (regs[5] !== 16'h0000) $display("FAIL rl_no_write: got %h expected 0000", regs[5]); else n_pass++;
    reset = 1;
    rsp1_ready = 1;
    req0_write = 0; req0_addr1 = 1;
    req1_valid = 1; req1_lock = 0;
    #1;
    n_checks++; if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL rl_first_tie: got %b expected 10", {req0_ready, req1_ready}); else n_pass++;
    @(negedge clk);
    idle_all();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_tie();
    test_swap();
    test_lock();
    test_backpressure();
    test_reset_in_lock();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_arbiter.md
# regfile_arbiter

- Shares the single 16×16-bit register file between two requesters:
  - port 0, the datapath control unit;
  - port 1, the debug/load port.
- Arbitrates one access per cycle, round-robin or fixed priority.
- Drives the register file's shared read/write address, write data and write enable.
- Returns each access's two read operands through a registered, back-pressurable response channel.
- Supports locked multi-beat sequences, e.g. atomic read-modify-write.

## Interface
Parameters:
- PRIO_MODE, 0: 0 = round-robin, 1 = fixed priority (port 0 always wins).

Ports. Both requester ports are identical; n = 0, 1.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low.
- reqn_valid  in  1  request present.
- reqn_ready  out  1  request accepted this cycle (combinational).
- reqn_write  in  1  1 = write wdata to addr1; 0 = read only.
- reqn_lock  in  1  keep grant for this port after this beat.
- reqn_addr1  in  4  first operand address; also the write address.
- reqn_addr2  in  4  second operand address.
- reqn_wdata  in  16  write data.
- rspn_valid  out  1  response holds data.
- rspn_ready  in  1  response consumed.
- rspn_op1  out  16  captured value at addr1.
- rspn_op2  out  16  captured value at addr2.
- rf_readReg1  out  4  register file address 1 / write address.
- rf_readReg2  out  4  register file address 2.
- rf_wrData  out  16  register file write data.
- rf_RegWrite  out  1  register file write enable.
- rf_op1  in  16  combinational read data 1.
- rf_op2  in  16  combinational read data 2.

## Operation
- **Eligibility.** Port n is eligible when reqn_valid=1 and its response slot is free: rspn_valid=0 or rspn_ready=1.
- **Grant, unlocked.**
  - Round-robin: if both ports are eligible, the port not granted last wins; otherwise the single eligible port wins.
  - PRIO_MODE=1: port 0 wins whenever it is eligible.
- **Grant, locked.** Only the lock owner can be granted. The other port's ready stays 0 even if the owner is idle.
- **Ready.** reqn_ready=1 exactly for the granted port; at most one ready is high per cycle.
- **Register file drive while granted.** rf_readReg1/2 = addr1/addr2, rf_RegWrite = write, rf_wrData = wdata.
- **Register file drive while idle.** All rf_* outputs are 0.
- **Response capture.** On the accept edge, rspn_op1/op2 <= rf_op1/rf_op2 and rspn_valid <= 1. For a write, op1 is therefore the pre-write value (swap semantics).
- **Response release.** rspn_valid clears on rspn_ready when no new accept occurs for that port in the same cycle. With ready and a new accept in the same cycle, the slot reloads and stays valid.
- **Lock FSM, states UNLOCKED and LOCKED(owner).**
  - UNLOCKED -> LOCKED(n): port n is accepted with lock=1.
  - LOCKED(n) -> UNLOCKED: port n is accepted with lock=0.
  - The lock is not released by deasserting valid.
- **Last-grant pointer.** Updates on every accept and is used only in round-robin.

## Timing
- **Request path.** The request-to-rf path is combinational in the accept cycle. Write data is visible in the register file from the next cycle.
- **Response latency.** rspn_valid rises 1 cycle after the accept.
- **Throughput.**
  - One access per cycle in total.
  - Back-to-back accepts per port are possible when rspn_ready=1.
  - Read-after-write in the following cycle returns the new data.
- **Reset values.** All rsp*_valid = 0, rsp*_op1/op2 = 0, lock state UNLOCKED, last-grant = port 1 (port 0 wins the first tie).
- **Idle outputs.** rf_* = 0 and req*_ready = 0.
- **Reset mid-lock or mid-response.** Pending responses are dropped, the lock is cleared and the pointer is reset. No register file write occurs while reset is low.
- **Stalled owner.** If the lock owner's response slot is full and unconsumed, no port is granted.

## Structure
- **Shared package (rf_pkg).**
  - Constants RF_AW=4 and RF_DW=16.
  - PRIO_RR / PRIO_FIXED encodings.
  - Lock FSM state encoding.
- **Sub-module.** One per-port response slot, `rf_rsp_slot`: valid flag plus two 16-bit holding registers, with load/consume inputs and a "free" output. It is instantiated twice.
- **Top level.** Grant logic, lock FSM, pointer and rf mux.

## Test plan
1. **Single read.** After reset (R1=1F00, R2=0054), req0 reads addr1=1, addr2=2 -> ready0 high the same cycle; next cycle rsp0_valid=1, op1=1F00, op2=0054.
2. **Tie and alternation.** Both ports valid every cycle, round-robin, rsp ready tied high -> grants 0,1,0,1; with PRIO_MODE=1 -> port 0 every cycle and ready1 never high.
3. **Swap write then read.** req1 writes addr1=3, wdata=1234 -> rsp1 op1=F70F. Next cycle req1 reads addr1=3 -> op1=1234.
4. **Lock.**
   - Stimulus: req0 lock=1 reads R8, while req1 stays valid; then req0 idles 3 cycles; then req0 lock=0 writes R8=5555.
   - Required: ready1 low throughout the lock; req1 is granted the cycle after the unlocking beat; rsp0 op1=AAAA for both beats.
5. **Backpressure.** rsp0_ready=0 with rsp0 full -> ready0 stays 0 while port 1 is still served. Asserting rsp0_ready with req0 valid -> reload in the same cycle, rsp0_valid stays 1.
6. **Async reset during lock.** Reset asserted during a lock with rsp1 valid -> all rsp valids 0 and lock cleared at once; the first tie after release goes to port 0.
